instr_fetch: RTL

- Fetch stage of the MIPS single-cycle CPU. Holds the PC and fetches instructions from instruction memory over a req/ack handshake.
- Presents the held instruction, and its opcode field to the Control decoder, until the downstream datapath accepts it.
- Consumes Jump/Branch from Control and Zero from the ALU at accept time to select the next PC.

---
 rtl/mips_pkg.sv | 20 ++
 rtl/next_pc_calc.sv | 29 ++
 rtl/instr_fetch.sv | 92 +++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS definitions: opcode constants, instruction width and the fetch
// state encoding used by the fetch stage and its helpers.
package mips_pkg;

   localparam int INSTR_W = 32;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_BEQ   = 6'b000100;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      VALID = 2'd2
   } fetch_state_e;

endpackage

// File: rtl/next_pc_calc.sv
// Next-PC selection for a single instruction: jump beats taken branch beats
// sequential pc+4. Purely combinational so a pipelined fetch can reuse it.
module next_pc_calc
   import mips_pkg::*;
(
   input  logic [31:0] pc,
   input  logic [25:0] ir,
   input  logic        jump,
   input  logic        branch,
   input  logic        zero,
   output logic [31:0] next_pc
);

   logic [31:0] pc4;
   logic [31:0] br_off;

   assign pc4    = pc + 32'd4;
   assign br_off = {{14{ir[15]}}, ir[15:0], 2'b00};

   always_comb begin
      next_pc = pc4;
      if (jump) begin
         next_pc = {pc4[31:28], ir, 2'b00};
      end else if (branch && zero) begin
         next_pc = pc4 + br_off;
      end
   end

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: holds the PC, fetches one instruction word over req/ack, and
// presents it until the datapath accepts it, then advances to the next PC.
//
// state | meaning
// IDLE  | one quiet cycle after reset, no request
// FETCH | request outstanding at pc, waiting for ack
// VALID | instruction held in ir, waiting for ready
module instr_fetch
   import mips_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          RETIRE_W = 32
)
(
   input  logic                clk_i,
   input  logic                rst_i,
   output logic                imem_req_o,
   output logic [31:0]         imem_addr_o,
   input  logic                imem_ack_i,
   input  logic [INSTR_W-1:0]  imem_data_i,
   output logic [INSTR_W-1:0]  instr_o,
   output logic [5:0]          op_o,
   output logic                instr_valid_o,
   input  logic                instr_ready_i,
   input  logic                jump_i,
   input  logic                branch_i,
   input  logic                zero_i,
   output logic [31:0]         pc_o,
   output logic [RETIRE_W-1:0] retire_cnt_o
);

   localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

   fetch_state_e        state;
   fetch_state_e        state_nxt;
   logic [31:0]         pc;
   logic [INSTR_W-1:0]  ir;
   logic [RETIRE_W-1:0] retire_cnt;
   logic [31:0]         next_pc;
   logic                capture;
   logic                accept;

   assign capture = (state == FETCH) && imem_ack_i;
   assign accept  = (state == VALID) && instr_ready_i;

   next_pc_calc u_next_pc_calc (
      .pc      (pc),
      .ir      (ir[25:0]),
      .jump    (jump_i),
      .branch  (branch_i),
      .zero    (zero_i),
      .next_pc (next_pc)
   );

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    state_nxt = FETCH;
         FETCH:   if (imem_ack_i) state_nxt = VALID;
         VALID:   if (instr_ready_i) state_nxt = FETCH;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state      <= IDLE;
         pc         <= RESET_PC_ALIGNED;
         ir         <= '0;
         retire_cnt <= '0;
      end else begin
         state <= state_nxt;
         if (capture) begin
            ir <= imem_data_i;
         end
         // next_pc is word aligned because pc and every offset are.
         if (accept) begin
            pc         <= next_pc;
            retire_cnt <= retire_cnt + RETIRE_W'(1);
         end
      end
   end

   assign imem_req_o    = (state == FETCH);
   assign imem_addr_o   = pc;
   assign instr_valid_o = (state == VALID);
   assign instr_o       = ir;
   assign op_o          = ir[31:26];
   assign pc_o          = pc;
   assign retire_cnt_o  = retire_cnt;

endmodule
